cache_bus_arbiter: RTL

CACHE_BUS_ARBITER -- requirements
Module: cache_bus_arbiter

---
 rtl/cache_bus_arbiter_pkg.sv | 28 ++
 rtl/cache_bus_arbiter_line_wr_buffer.sv | 59 +++++
 rtl/cache_bus_arbiter.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/cache_bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cache_bus_arbiter_pkg
// Description : Constants and FSM state encodings for the cache bus arbiter.
//               The cache controllers import this package as well.
// Revision    : 1.0 - initial release
// ============================================================================
package cache_bus_arbiter_pkg;

    localparam int LINE_WORDS_DEF = 16;  // 32-bit beats per cache line
    localparam int WORD_W         = 32;  // beat width
    localparam int OFFSET_W       = 6;   // byte offset bits within a line
    localparam int BEAT_W         = 4;   // read beat counter width

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_ADDR = 2'd1,
        R_DATA = 2'd2
    } rd_state_e;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_ADDR = 2'd1,
        W_DATA = 2'd2
    } wr_state_e;

endpackage : cache_bus_arbiter_pkg
`default_nettype wire

// File: rtl/cache_bus_arbiter_line_wr_buffer.sv
`default_nettype none
// ============================================================================
// Module      : line_wr_buffer
// Description : Holds one dirty line for writeback and steps through it one
//               32-bit word per accepted beat.
// Ports       : clk, reset        - clock, synchronous active-high reset
//               load_i, line_i    - capture a full line (also rewinds index)
//               start_i           - rewind the beat index to word 0
//               adv_i             - advance to the next word
//               word_o, last_o    - current word, index is on the final word
// Revision    : 1.0 - initial release
// ============================================================================
module line_wr_buffer
    import cache_bus_arbiter_pkg::*;
#(
    parameter int LINE_WORDS = LINE_WORDS_DEF
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         load_i,
    input  logic [LINE_WORDS*WORD_W-1:0] line_i,
    input  logic                         start_i,
    input  logic                         adv_i,
    output logic [WORD_W-1:0]            word_o,
    output logic                         last_o
);

    localparam int IDX_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;

    logic [LINE_WORDS-1:0][WORD_W-1:0] line_q;
    logic [IDX_W-1:0]                  idx_q;
    logic [IDX_W-1:0]                  idx_d;

    always_comb begin
        idx_d = idx_q;
        if (load_i || start_i) begin
            idx_d = '0;
        end else if (adv_i) begin
            idx_d = idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            line_q <= '0;
            idx_q  <= '0;
        end else begin
            if (load_i) begin
                line_q <= line_i;
            end
            idx_q <= idx_d;
        end
    end

    assign word_o = line_q[idx_q];
    assign last_o = (idx_q == IDX_W'(LINE_WORDS - 1));

endmodule : line_wr_buffer
`default_nettype wire

// File: rtl/cache_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cache_bus_arbiter
// Description : Shares one memory port between I-cache and D-cache refills
//               (round-robin read FSM) and D-cache dirty-line writebacks
//               (buffered write FSM). Both FSMs run concurrently; a refill of
//               a line that is being written back waits for the writeback.
// Ports       : clk, reset                - clock, sync active-high reset
//               ic_rd_* / dc_rd_*         - refill request/ack per cache
//               ic_ret_* / dc_ret_*       - refill beats routed to requester
//               dc_wr_*                   - writeback request and line data
//               mem_rd_* / mem_ret_*      - memory read address / return
//               mem_wr_*                  - memory write address / beats
// Revision    : 1.0 - initial release
// ============================================================================
module cache_bus_arbiter
    import cache_bus_arbiter_pkg::*;
#(
    parameter int LINE_WORDS = LINE_WORDS_DEF,
    parameter int ADDR_W     = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         ic_rd_req,
    input  logic [ADDR_W-1:0]            ic_rd_addr,
    output logic                         ic_rd_rdy,
    output logic                         ic_ret_valid,
    output logic                         ic_ret_last,
    output logic [WORD_W-1:0]            ic_ret_data,
    input  logic                         dc_rd_req,
    input  logic [ADDR_W-1:0]            dc_rd_addr,
    output logic                         dc_rd_rdy,
    output logic                         dc_ret_valid,
    output logic                         dc_ret_last,
    output logic [WORD_W-1:0]            dc_ret_data,
    input  logic                         dc_wr_req,
    input  logic [ADDR_W-1:0]            dc_wr_addr,
    input  logic [LINE_WORDS*WORD_W-1:0] dc_wr_data,
    output logic                         dc_wr_rdy,
    output logic                         mem_rd_req,
    output logic [ADDR_W-1:0]            mem_rd_addr,
    input  logic                         mem_rd_rdy,
    input  logic                         mem_ret_valid,
    input  logic                         mem_ret_last,
    input  logic [WORD_W-1:0]            mem_ret_data,
    output logic                         mem_wr_req,
    output logic [ADDR_W-1:0]            mem_wr_addr,
    input  logic                         mem_wr_rdy,
    output logic                         mem_wr_valid,
    output logic [WORD_W-1:0]            mem_wr_data,
    output logic                         mem_wr_last,
    input  logic                         mem_wr_ready
);

    localparam int LINE_AW = ADDR_W - OFFSET_W;

    // ---------------- state ----------------
    rd_state_e          rd_state_q, rd_state_d;
    logic               rd_gnt_dc_q, rd_gnt_dc_d;   // 1: D-cache owns the read
    logic [LINE_AW-1:0] rd_line_q, rd_line_d;
    logic               rr_dc_q, rr_dc_d;           // 1: D-cache wins a tie
    logic [BEAT_W-1:0]  beat_cnt_q, beat_cnt_d;

    wr_state_e          wr_state_q, wr_state_d;
    logic [LINE_AW-1:0] wr_line_q, wr_line_d;

    logic               w_buf_load, w_buf_start, w_buf_adv, w_buf_last;
    logic [WORD_W-1:0]  w_buf_word;

    // ---------------- read eligibility ----------------
    // A refill must not overtake a writeback of the same line. That covers a
    // writeback already buffered and one being accepted in this very cycle.
    logic w_wr_accept, w_ic_hazard, w_dc_hazard, w_ic_elig, w_dc_elig, w_pick_dc;

    assign w_wr_accept = !reset && (wr_state_q == W_IDLE) && dc_wr_req;

    assign w_ic_hazard = ((wr_state_q != W_IDLE) && (ic_rd_addr[ADDR_W-1:OFFSET_W] == wr_line_q))
                      || (w_wr_accept && (ic_rd_addr[ADDR_W-1:OFFSET_W] == dc_wr_addr[ADDR_W-1:OFFSET_W]));
    assign w_dc_hazard = ((wr_state_q != W_IDLE) && (dc_rd_addr[ADDR_W-1:OFFSET_W] == wr_line_q))
                      || (w_wr_accept && (dc_rd_addr[ADDR_W-1:OFFSET_W] == dc_wr_addr[ADDR_W-1:OFFSET_W]));

    assign w_ic_elig = ic_rd_req && !w_ic_hazard;
    assign w_dc_elig = dc_rd_req && !w_dc_hazard;
    assign w_pick_dc = w_dc_elig && (!w_ic_elig || rr_dc_q);

    // ---------------- read FSM ----------------
    always_comb begin
        rd_state_d   = rd_state_q;
        rd_gnt_dc_d  = rd_gnt_dc_q;
        rd_line_d    = rd_line_q;
        rr_dc_d      = rr_dc_q;
        beat_cnt_d   = beat_cnt_q;
        mem_rd_req   = 1'b0;
        ic_rd_rdy    = 1'b0;
        dc_rd_rdy    = 1'b0;
        ic_ret_valid = 1'b0;
        ic_ret_last  = 1'b0;
        dc_ret_valid = 1'b0;
        dc_ret_last  = 1'b0;
        if (!reset) begin
            case (rd_state_q)
                R_IDLE: begin
                    if (w_ic_elig || w_dc_elig) begin
                        rd_gnt_dc_d = w_pick_dc;
                        rd_line_d   = w_pick_dc ? dc_rd_addr[ADDR_W-1:OFFSET_W]
                                                : ic_rd_addr[ADDR_W-1:OFFSET_W];
                        // The pointer only moves on a real contest, so a lone
                        // request does not steal the other side's next turn.
                        if (w_ic_elig && w_dc_elig) begin
                            rr_dc_d = !w_pick_dc;
                        end
                        rd_state_d = R_ADDR;
                    end
                end
                R_ADDR: begin
                    mem_rd_req = 1'b1;
                    if (mem_rd_rdy) begin
                        ic_rd_rdy  = !rd_gnt_dc_q;
                        dc_rd_rdy  = rd_gnt_dc_q;
                        beat_cnt_d = '0;
                        rd_state_d = R_DATA;
                    end
                end
                R_DATA: begin
                    ic_ret_valid = mem_ret_valid && !rd_gnt_dc_q;
                    ic_ret_last  = mem_ret_valid && mem_ret_last && !rd_gnt_dc_q;
                    dc_ret_valid = mem_ret_valid && rd_gnt_dc_q;
                    dc_ret_last  = mem_ret_valid && mem_ret_last && rd_gnt_dc_q;
                    if (mem_ret_valid) begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                        if (mem_ret_last) begin
                            rd_state_d = R_IDLE;
                        end
                    end
                end
                default: rd_state_d = R_IDLE;
            endcase
        end
    end

    // ---------------- write FSM ----------------
    always_comb begin
        wr_state_d   = wr_state_q;
        wr_line_d    = wr_line_q;
        w_buf_load   = 1'b0;
        w_buf_start  = 1'b0;
        w_buf_adv    = 1'b0;
        dc_wr_rdy    = 1'b0;
        mem_wr_req   = 1'b0;
        mem_wr_valid = 1'b0;
        mem_wr_last  = 1'b0;
        if (!reset) begin
            case (wr_state_q)
                W_IDLE: begin
                    dc_wr_rdy = 1'b1;
                    if (dc_wr_req) begin
                        wr_line_d  = dc_wr_addr[ADDR_W-1:OFFSET_W];
                        w_buf_load = 1'b1;
                        wr_state_d = W_ADDR;
                    end
                end
                W_ADDR: begin
                    mem_wr_req = 1'b1;
                    if (mem_wr_rdy) begin
                        w_buf_start = 1'b1;
                        wr_state_d  = W_DATA;
                    end
                end
                W_DATA: begin
                    mem_wr_valid = 1'b1;
                    mem_wr_last  = w_buf_last;
                    if (mem_wr_ready) begin
                        w_buf_adv = 1'b1;
                        if (w_buf_last) begin
                            wr_state_d = W_IDLE;
                        end
                    end
                end
                default: wr_state_d = W_IDLE;
            endcase
        end
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_state_q  <= R_IDLE;
            rd_gnt_dc_q <= 1'b0;
            rd_line_q   <= '0;
            rr_dc_q     <= 1'b1;
            beat_cnt_q  <= '0;
            wr_state_q  <= W_IDLE;
            wr_line_q   <= '0;
        end else begin
            rd_state_q  <= rd_state_d;
            rd_gnt_dc_q <= rd_gnt_dc_d;
            rd_line_q   <= rd_line_d;
            rr_dc_q     <= rr_dc_d;
            beat_cnt_q  <= beat_cnt_d;
            wr_state_q  <= wr_state_d;
            wr_line_q   <= wr_line_d;
        end
    end

    line_wr_buffer #(
        .LINE_WORDS (LINE_WORDS)
    ) u_line_wr_buffer (
        .clk     (clk),
        .reset   (reset),
        .load_i  (w_buf_load),
        .line_i  (dc_wr_data),
        .start_i (w_buf_start),
        .adv_i   (w_buf_adv),
        .word_o  (w_buf_word),
        .last_o  (w_buf_last)
    );

    // ---------------- datapath outputs ----------------
    assign mem_rd_addr = {rd_line_q, {OFFSET_W{1'b0}}};
    assign mem_wr_addr = {wr_line_q, {OFFSET_W{1'b0}}};
    assign mem_wr_data = w_buf_word;
    assign ic_ret_data = mem_ret_data;
    assign dc_ret_data = mem_ret_data;

    // Byte offsets of line addresses carry no information here.
    logic unused_offsets;
    assign unused_offsets = ^{ic_rd_addr[OFFSET_W-1:0], dc_rd_addr[OFFSET_W-1:0],
                              dc_wr_addr[OFFSET_W-1:0]};

endmodule : cache_bus_arbiter
`default_nettype wire
